// File: rtl/cpu_bus_ctrl_pkg.sv
// Shared memory-map constants, target/state encodings and chip-select helper for cpu_bus_ctrl.
package cpu_bus_ctrl_pkg;

  localparam int unsigned AB_W      = 16;
  localparam int unsigned PA_W      = 21;
  localparam int unsigned DB_W      = 8;
  localparam int unsigned RAMBANK_W = 8;
  localparam int unsigned ROMBANK_W = 5;
  localparam int unsigned CS_W      = 4;

  localparam logic [7:0]      IO_PAGE_DEF     = 8'h9F;
  localparam logic [1:0]      ROM_BASE_HI_DEF = 2'b11;
  localparam logic [AB_W-1:0] RAMBANK_ADDR    = 16'h0000;
  localparam logic [AB_W-1:0] ROMBANK_ADDR    = 16'h0001;

  // IO page sub-ranges (offsets within the page)
  localparam logic [7:0] VIA_HI  = 8'h0F;
  localparam logic [7:0] VERA_LO = 8'h20;
  localparam logic [7:0] VERA_HI = 8'h3F;
  localparam logic [7:0] NORA_LO = 8'h50;
  localparam logic [7:0] NORA_HI = 8'h7F;

  // Region selectors on the CPU address
  localparam logic [2:0] RAM_WIN_HI3 = 3'b101;
  localparam logic [1:0] ROM_WIN_HI2 = 2'b11;

  typedef enum logic [2:0] {
    TGT_NONE,
    TGT_SRAM,
    TGT_VIA,
    TGT_VERA,
    TGT_NORA
  } tgt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_WRITE,
    ST_WHOLD
  } bus_state_e;

  // Low-active select vector {nora, vera, via, sram} for a target
  function automatic logic [CS_W-1:0] cs_lo(input tgt_e t);
    logic [CS_W-1:0] v;
    v = 4'b1111;
    case (t)
      TGT_SRAM: v = 4'b1110;
      TGT_VIA:  v = 4'b1101;
      TGT_VERA: v = 4'b1011;
      TGT_NORA: v = 4'b0111;
      default:  v = 4'b1111;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cpu_addr_decode.sv
// Combinational CPU address decode: banked 21-bit physical address, target and write permission.
// CPU_BUS_ROM_WP_EN defined: the ROM window ($C000-$FFFF) is reported not writable.
module cpu_addr_decode
  import cpu_bus_ctrl_pkg::*;
#(
  parameter logic [7:0] IO_PAGE     = IO_PAGE_DEF,
  parameter logic [1:0] ROM_BASE_HI = ROM_BASE_HI_DEF
) (
  input  logic [15:0] i_ab,
  input  logic [7:0]  i_ram_bank,
  input  logic [4:0]  i_rom_bank,
  output logic [20:0] o_phys_addr,
  output tgt_e        o_target,
  output logic        o_wr_ok
);

  logic [7:0] w_off;
  assign w_off = i_ab[7:0];

  always_comb begin
    o_phys_addr = {5'b0, i_ab};
    o_target    = TGT_SRAM;
    o_wr_ok     = 1'b1;
    if (i_ab[15:8] == IO_PAGE) begin
      // IO window never touches SRAM; unmapped offsets select nothing
      if (w_off <= VIA_HI)
        o_target = TGT_VIA;
      else if (w_off >= VERA_LO && w_off <= VERA_HI)
        o_target = TGT_VERA;
      else if (w_off >= NORA_LO && w_off <= NORA_HI)
        o_target = TGT_NORA;
      else
        o_target = TGT_NONE;
    end else if (i_ab[15:13] == RAM_WIN_HI3) begin
      o_phys_addr = {i_ram_bank, i_ab[12:0]};
    end else if (i_ab[15:14] == ROM_WIN_HI2) begin
      o_phys_addr = {ROM_BASE_HI, i_rom_bank, i_ab[13:0]};
`ifdef CPU_BUS_ROM_WP_EN
      o_wr_ok     = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU bus controller: latches the 65C02 address, banks it into SRAM space and times CS/OE/WE strobes.
// CPU_BUS_ROM_WP_EN defined: writes to $C000-$FFFF keep mem_wrn high (default build: ROM window writable).
module cpu_bus_ctrl
  import cpu_bus_ctrl_pkg::*;
#(
  parameter logic [7:0] IO_PAGE     = IO_PAGE_DEF,
  parameter logic [1:0] ROM_BASE_HI = ROM_BASE_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cphi2,
  input  logic        latch_ad,
  input  logic        setup_cs,
  input  logic        release_wr,
  input  logic        release_cs,
  input  logic [15:0] cpu_ab,
  input  logic        cpu_rwn,
  input  logic [7:0]  cpu_db,
  output logic [20:0] mem_addr,
  output logic        sram_csn,
  output logic        mem_rdn,
  output logic        mem_wrn,
  output logic        via_csn,
  output logic        vera_csn,
  output logic        nora_csn,
  output logic [7:0]  ram_bank,
  output logic [4:0]  rom_bank,
  output logic        proto_err
);

  logic [PA_W-1:0]      w_phys;
  tgt_e                 w_tgt;
  logic                 w_wr_ok;
  logic [1:0]           w_bank_sel;

  bus_state_e           r_state;
  logic [PA_W-1:0]      r_mem_addr;
  logic                 r_rwn;
  tgt_e                 r_tgt;
  logic                 r_wr_ok;
  logic [1:0]           r_bank_sel;
  logic [CS_W-1:0]      r_csn;
  logic                 r_rdn;
  logic                 r_wrn;
  logic [RAMBANK_W-1:0] r_ram_bank;
  logic [ROMBANK_W-1:0] r_rom_bank;
  logic                 r_proto_err;

  cpu_addr_decode #(
    .IO_PAGE     (IO_PAGE),
    .ROM_BASE_HI (ROM_BASE_HI)
  ) u_decode (
    .i_ab        (cpu_ab),
    .i_ram_bank  (r_ram_bank),
    .i_rom_bank  (r_rom_bank),
    .o_phys_addr (w_phys),
    .o_target    (w_tgt),
    .o_wr_ok     (w_wr_ok)
  );

  // {rombank reg, rambank reg} hit on the latched address
  assign w_bank_sel = {cpu_ab == ROMBANK_ADDR, cpu_ab == RAMBANK_ADDR};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mem_addr  <= '0;
      r_rwn       <= 1'b1;
      r_tgt       <= TGT_NONE;
      r_wr_ok     <= 1'b0;
      r_bank_sel  <= 2'b00;
      r_csn       <= 4'b1111;
      r_rdn       <= 1'b1;
      r_wrn       <= 1'b1;
      r_ram_bank  <= '0;
      r_rom_bank  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (latch_ad) begin
        r_mem_addr <= w_phys;
        r_rwn      <= cpu_rwn;
        r_tgt      <= w_tgt;
        r_wr_ok    <= w_wr_ok;
        r_bank_sel <= w_bank_sel;
      end

      // A new setup_cs always wins; outside IDLE it aborts the running cycle
      if (setup_cs) begin
        if (r_state != ST_IDLE)
          r_proto_err <= 1'b1;
        r_state <= ST_ACTIVE;
        r_csn   <= cs_lo(r_tgt);
        r_rdn   <= ~(r_rwn && (r_tgt == TGT_SRAM));
        r_wrn   <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_csn <= 4'b1111;
            r_rdn <= 1'b1;
            r_wrn <= 1'b1;
          end
          ST_ACTIVE: begin
            if (release_cs) begin
              r_state <= ST_IDLE;
              r_csn   <= 4'b1111;
              r_rdn   <= 1'b1;
              r_wrn   <= 1'b1;
            end else if (cphi2 && !r_rwn && (r_tgt == TGT_SRAM)) begin
              r_state <= ST_WRITE;
              r_wrn   <= ~r_wr_ok;
            end
          end
          ST_WRITE: begin
            if (release_wr) begin
              if (r_bank_sel[0])
                r_ram_bank <= cpu_db;
              if (r_bank_sel[1])
                r_rom_bank <= cpu_db[ROMBANK_W-1:0];
            end
            if (release_cs) begin
              r_state <= ST_IDLE;
              r_csn   <= 4'b1111;
              r_rdn   <= 1'b1;
              r_wrn   <= 1'b1;
            end else if (release_wr) begin
              r_state <= ST_WHOLD;
              r_wrn   <= 1'b1;
            end
          end
          ST_WHOLD: begin
            if (release_cs) begin
              r_state <= ST_IDLE;
              r_csn   <= 4'b1111;
              r_rdn   <= 1'b1;
              r_wrn   <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign sram_csn  = r_csn[0];
  assign via_csn   = r_csn[1];
  assign vera_csn  = r_csn[2];
  assign nora_csn  = r_csn[3];
  assign mem_rdn   = r_rdn;
  assign mem_wrn   = r_wrn;
  assign ram_bank  = r_ram_bank;
  assign rom_bank  = r_rom_bank;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed table-driven bench for cpu_bus_ctrl plus hand sequences for protocol corner cases.
module tb_cpu_bus_ctrl;

  logic        clk;
  logic        reset;
  logic        cphi2;
  logic        latch_ad;
  logic        setup_cs;
  logic        release_wr;
  logic        release_cs;
  logic [15:0] cpu_ab;
  logic        cpu_rwn;
  logic [7:0]  cpu_db;
  logic [20:0] mem_addr;
  logic        sram_csn;
  logic        mem_rdn;
  logic        mem_wrn;
  logic        via_csn;
  logic        vera_csn;
  logic        nora_csn;
  logic [7:0]  ram_bank;
  logic [4:0]  rom_bank;
  logic        proto_err;

  cpu_bus_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cphi2      (cphi2),
    .latch_ad   (latch_ad),
    .setup_cs   (setup_cs),
    .release_wr (release_wr),
    .release_cs (release_cs),
    .cpu_ab     (cpu_ab),
    .cpu_rwn    (cpu_rwn),
    .cpu_db     (cpu_db),
    .mem_addr   (mem_addr),
    .sram_csn   (sram_csn),
    .mem_rdn    (mem_rdn),
    .mem_wrn    (mem_wrn),
    .via_csn    (via_csn),
    .vera_csn   (vera_csn),
    .nora_csn   (nora_csn),
    .ram_bank   (ram_bank),
    .rom_bank   (rom_bank),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Low-active selects {nora, vera, via, sram}
  localparam logic [3:0] CS_NONE = 4'b1111;
  localparam logic [3:0] CS_SRAM = 4'b1110;
  localparam logic [3:0] CS_VIA  = 4'b1101;
  localparam logic [3:0] CS_VERA = 4'b1011;
  localparam logic [3:0] CS_NORA = 4'b0111;

`ifdef CPU_BUS_ROM_WP_EN
  localparam logic ROM_WRN = 1'b1;
`else
  localparam logic ROM_WRN = 1'b0;
`endif

  typedef struct {
    logic [15:0] ab;
    logic        rwn;
    logic [7:0]  db;
    logic [20:0] exp_addr;
    logic [3:0]  exp_cs;
    logic        exp_rdn;
    logic        exp_wrn;
    logic [7:0]  exp_rb;
    logic [4:0]  exp_ob;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] cs_now();
    return {nora_csn, vera_csn, via_csn, sram_csn};
  endfunction

  task automatic start_cycle(input logic [15:0] ab, input logic rwn, input logic [7:0] db);
    cpu_ab = ab; cpu_rwn = rwn; cpu_db = db;
    latch_ad = 1'b1; tick(); latch_ad = 1'b0;
    setup_cs = 1'b1; tick(); setup_cs = 1'b0;
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{16'h1234, 1'b1, 8'h00, 21'h001234, CS_SRAM, 1'b0, 1'b1,    8'h00, 5'h00};
    vecs[1]  = '{16'h0000, 1'b0, 8'h05, 21'h000000, CS_SRAM, 1'b1, 1'b0,    8'h05, 5'h00};
    vecs[2]  = '{16'hA010, 1'b1, 8'h00, 21'h00A010, CS_SRAM, 1'b0, 1'b1,    8'h05, 5'h00};
    vecs[3]  = '{16'h0001, 1'b0, 8'h03, 21'h000001, CS_SRAM, 1'b1, 1'b0,    8'h05, 5'h03};
    vecs[4]  = '{16'hC100, 1'b1, 8'h00, 21'h18C100, CS_SRAM, 1'b0, 1'b1,    8'h05, 5'h03};
    vecs[5]  = '{16'hC100, 1'b0, 8'h77, 21'h18C100, CS_SRAM, 1'b1, ROM_WRN, 8'h05, 5'h03};
    vecs[6]  = '{16'h9F23, 1'b0, 8'h11, 21'h009F23, CS_VERA, 1'b1, 1'b1,    8'h05, 5'h03};
    vecs[7]  = '{16'h9F40, 1'b0, 8'h22, 21'h009F40, CS_NONE, 1'b1, 1'b1,    8'h05, 5'h03};
    vecs[8]  = '{16'h2000, 1'b0, 8'hAA, 21'h002000, CS_SRAM, 1'b1, 1'b0,    8'h05, 5'h03};
    vecs[9]  = '{16'h9F05, 1'b1, 8'h00, 21'h009F05, CS_VIA,  1'b1, 1'b1,    8'h05, 5'h03};
    vecs[10] = '{16'h9F60, 1'b1, 8'h00, 21'h009F60, CS_NORA, 1'b1, 1'b1,    8'h05, 5'h03};
    vecs[11] = '{16'h9EFF, 1'b1, 8'h00, 21'h009EFF, CS_SRAM, 1'b0, 1'b1,    8'h05, 5'h03};
    vecs[12] = '{16'h0000, 1'b0, 8'h81, 21'h000000, CS_SRAM, 1'b1, 1'b0,    8'h81, 5'h03};
    vecs[13] = '{16'hBFFF, 1'b1, 8'h00, 21'h103FFF, CS_SRAM, 1'b0, 1'b1,    8'h81, 5'h03};
    vecs[14] = '{16'h0001, 1'b1, 8'h00, 21'h000001, CS_SRAM, 1'b0, 1'b1,    8'h81, 5'h03};
    vecs[15] = '{16'h0001, 1'b0, 8'hFF, 21'h000001, CS_SRAM, 1'b1, 1'b0,    8'h81, 5'h1F};
    vecs[16] = '{16'hFFFF, 1'b1, 8'h00, 21'h1FFFFF, CS_SRAM, 1'b0, 1'b1,    8'h81, 5'h1F};

    reset = 1'b1; cphi2 = 1'b0; latch_ad = 1'b0; setup_cs = 1'b0;
    release_wr = 1'b0; release_cs = 1'b0; cpu_ab = 16'h0; cpu_rwn = 1'b1; cpu_db = 8'h0;
    tick(); tick();
    reset = 1'b0;

    chk("rst cs",        32'(cs_now()), 32'(CS_NONE));
    chk("rst rdn/wrn",   32'({mem_rdn, mem_wrn}), 32'h3);
    chk("rst addr",      32'(mem_addr), 32'h0);
    chk("rst banks",     32'({ram_bank, rom_bank}), 32'h0);
    chk("rst proto_err", 32'(proto_err), 32'h0);

    // Stray releases while idle are ignored without error
    release_wr = 1'b1; release_cs = 1'b1; tick(); release_wr = 1'b0; release_cs = 1'b0;
    chk("idle release cs",  32'(cs_now()), 32'(CS_NONE));
    chk("idle release err", 32'(proto_err), 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      v = vecs[i];
      cpu_ab = v.ab; cpu_rwn = v.rwn; cpu_db = v.db;
      latch_ad = 1'b1; tick(); latch_ad = 1'b0;
      chk($sformatf("v%0d addr", i), 32'(mem_addr), 32'(v.exp_addr));
      chk($sformatf("v%0d pre-cs", i), 32'(cs_now()), 32'(CS_NONE));
      setup_cs = 1'b1; tick(); setup_cs = 1'b0;
      chk($sformatf("v%0d cs", i), 32'(cs_now()), 32'(v.exp_cs));
      chk($sformatf("v%0d rdn", i), 32'(mem_rdn), 32'(v.exp_rdn));
      chk($sformatf("v%0d wrn pre-phi2", i), 32'(mem_wrn), 32'h1);
      cphi2 = 1'b1; tick();
      chk($sformatf("v%0d wrn phi2", i), 32'(mem_wrn), 32'(v.exp_wrn));
      chk($sformatf("v%0d cs phi2", i), 32'(cs_now()), 32'(v.exp_cs));
      if (!v.rwn) begin
        release_wr = 1'b1; tick(); release_wr = 1'b0;
        chk($sformatf("v%0d wrn hold", i), 32'(mem_wrn), 32'h1);
        chk($sformatf("v%0d cs hold", i), 32'(cs_now()), 32'(v.exp_cs));
      end
      cphi2 = 1'b0; release_cs = 1'b1; tick(); release_cs = 1'b0;
      chk($sformatf("v%0d end strobes", i), 32'({cs_now(), mem_rdn, mem_wrn}), 32'h3F);
      chk($sformatf("v%0d banks", i), 32'({ram_bank, rom_bank}), 32'({v.exp_rb, v.exp_ob}));
      chk($sformatf("v%0d proto_err", i), 32'(proto_err), 32'h0);
    end

    // release_wr and release_cs together in WRITE end the cycle in one edge
    start_cycle(16'h3000, 1'b0, 8'h5A);
    cphi2 = 1'b1; tick();
    chk("dual wrn low", 32'(mem_wrn), 32'h0);
    release_wr = 1'b1; release_cs = 1'b1; tick();
    release_wr = 1'b0; release_cs = 1'b0; cphi2 = 1'b0;
    chk("dual strobes", 32'({sram_csn, mem_rdn, mem_wrn}), 32'h7);
    cpu_rwn = 1'b1; latch_ad = 1'b1; tick(); latch_ad = 1'b0;
    setup_cs = 1'b1; tick(); setup_cs = 1'b0;
    chk("dual back idle", 32'(proto_err), 32'h0);
    release_cs = 1'b1; tick(); release_cs = 1'b0;

    // setup_cs inside ACTIVE flags the sticky error and restarts the cycle
    start_cycle(16'h1234, 1'b1, 8'h00);
    setup_cs = 1'b1; tick(); setup_cs = 1'b0;
    chk("proto set", 32'(proto_err), 32'h1);
    chk("proto restart", 32'({sram_csn, mem_rdn}), 32'h0);
    release_cs = 1'b1; tick(); release_cs = 1'b0;
    chk("proto end cs", 32'(sram_csn), 32'h1);
    tick();
    chk("proto sticky", 32'(proto_err), 32'h1);

    // Reset during WRITE drops every strobe and blocks the bank write
    start_cycle(16'h0000, 1'b0, 8'h42);
    cphi2 = 1'b1; tick();
    chk("rstw wrn low", 32'(mem_wrn), 32'h0);
    reset = 1'b1; release_wr = 1'b1; tick();
    reset = 1'b0; release_wr = 1'b0; cphi2 = 1'b0;
    chk("rstw strobes", 32'({cs_now(), mem_rdn, mem_wrn}), 32'h3F);
    chk("rstw banks",   32'({ram_bank, rom_bank}), 32'h0);
    chk("rstw proto",   32'(proto_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
